// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame controller: preamble/SFD strip, sof/eof framing,
// FCS/length/DA checking and saturating debug counters.
module gmii_rx_frame_ctrl #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter bit          DA_FILTER = 1'b1
) (
    input  logic        gmii_rxc,
    input  logic        rst,
    input  logic        gmii_rx_en,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [10:0] frame_len,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_bad,
    output logic [15:0] cnt_drop
);

    typedef enum logic [1:0] {WAIT_GAP, IDLE, PREAMBLE, DATA} state_t;

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT  = 11'h7FF;
    localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

    state_t      state_q;
    logic [2:0]  pre_cnt_q;
    logic [31:0] crc_q;
    logic [10:0] len_q;
    logic        uc_bad_q, bc_bad_q;
    logic [7:0]  hold_q;
    logic        hold_vld_q, hold_first_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q;
    logic [10:0] frame_len_q;
    logic [15:0] cnt_good_q, cnt_bad_q, cnt_drop_q;

    logic [31:0] crc_d;
    logic [7:0]  mac_byte_d;
    logic        da_bad_d;
    logic        frame_bad_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        crc_d = crc32_byte(crc_q, gmii_rxd);
        case (len_q[2:0])
            3'd0:    mac_byte_d = LOCAL_MAC[47:40];
            3'd1:    mac_byte_d = LOCAL_MAC[39:32];
            3'd2:    mac_byte_d = LOCAL_MAC[31:24];
            3'd3:    mac_byte_d = LOCAL_MAC[23:16];
            3'd4:    mac_byte_d = LOCAL_MAC[15:8];
            3'd5:    mac_byte_d = LOCAL_MAC[7:0];
            default: mac_byte_d = '0;
        endcase
        // DA is bad only if it matches neither the unicast nor the broadcast address
        da_bad_d    = (uc_bad_q && bc_bad_q) || (len_q < 11'd6);
        frame_bad_d = (crc_q != CRC_RES) || (len_q < MIN_L) || (len_q > MAX_L)
                      || (DA_FILTER && da_bad_d);
    end

    always_ff @(posedge gmii_rxc or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_GAP;
            pre_cnt_q    <= '0;
            crc_q        <= '1;
            len_q        <= '0;
            uc_bad_q     <= 1'b0;
            bc_bad_q     <= 1'b0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            rx_eof_q     <= 1'b0;
            rx_err_q     <= 1'b0;
            frame_len_q  <= '0;
            cnt_good_q   <= '0;
            cnt_bad_q    <= '0;
            cnt_drop_q   <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_sof_q   <= 1'b0;
            rx_eof_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state_q)
                WAIT_GAP: begin
                    if (!gmii_rx_en) state_q <= IDLE;
                end
                IDLE: begin
                    if (gmii_rx_en) begin
                        if (gmii_rxd == 8'h55) begin
                            state_q   <= PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q    <= WAIT_GAP;
                            cnt_drop_q <= sat_inc(cnt_drop_q);
                        end
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rx_en) begin
                        state_q    <= IDLE;
                        cnt_drop_q <= sat_inc(cnt_drop_q);
                    end else if (gmii_rxd == 8'h55) begin
                        if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
                    end else if (gmii_rxd == 8'hD5) begin
                        state_q    <= DATA;
                        len_q      <= '0;
                        crc_q      <= '1;
                        uc_bad_q   <= 1'b0;
                        bc_bad_q   <= 1'b0;
                        hold_vld_q <= 1'b0;
                    end else begin
                        state_q    <= WAIT_GAP;
                        cnt_drop_q <= sat_inc(cnt_drop_q);
                    end
                end
                DATA: begin
                    if (gmii_rx_en) begin
                        crc_q <= crc_d;
                        if (len_q != LEN_SAT) len_q <= len_q + 11'd1;
                        if (len_q < 11'd6) begin
                            uc_bad_q <= uc_bad_q | (gmii_rxd != mac_byte_d);
                            bc_bad_q <= bc_bad_q | (gmii_rxd != 8'hFF);
                        end
                        // One-byte hold stage: a byte is released only once we know
                        // whether another follows, so eof can ride on the last byte.
                        if (hold_vld_q) begin
                            rx_data_q  <= hold_q;
                            rx_valid_q <= 1'b1;
                            rx_sof_q   <= hold_first_q;
                        end
                        hold_q       <= gmii_rxd;
                        hold_vld_q   <= 1'b1;
                        hold_first_q <= (len_q == 11'd0);
                    end else begin
                        state_q    <= IDLE;
                        hold_vld_q <= 1'b0;
                        if (hold_vld_q) begin
                            rx_data_q   <= hold_q;
                            rx_valid_q  <= 1'b1;
                            rx_sof_q    <= hold_first_q;
                            rx_eof_q    <= 1'b1;
                            rx_err_q    <= frame_bad_d;
                            frame_len_q <= len_q;
                            if (frame_bad_d) cnt_bad_q  <= sat_inc(cnt_bad_q);
                            else             cnt_good_q <= sat_inc(cnt_good_q);
                        end else begin
                            cnt_bad_q <= sat_inc(cnt_bad_q);
                        end
                    end
                end
                default: state_q <= WAIT_GAP;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_sof    = rx_sof_q;
    assign rx_eof    = rx_eof_q;
    assign rx_err    = rx_err_q;
    assign frame_len = frame_len_q;
    assign cnt_good  = cnt_good_q;
    assign cnt_bad   = cnt_bad_q;
    assign cnt_drop  = cnt_drop_q;

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed, table-driven bench for gmii_rx_frame_ctrl with hand-built frames
// and a bench-side FCS generator.
module tb_gmii_rx_frame_ctrl;

    logic        gmii_rxc = 1'b0;
    logic        rst = 1'b1;
    logic        gmii_rx_en = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err;
    logic [10:0] frame_len;
    logic [15:0] cnt_good, cnt_bad, cnt_drop;

    gmii_rx_frame_ctrl dut (
        .gmii_rxc  (gmii_rxc),
        .rst       (rst),
        .gmii_rx_en(gmii_rx_en),
        .gmii_rxd  (gmii_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_err    (rx_err),
        .frame_len (frame_len),
        .cnt_good  (cnt_good),
        .cnt_bad   (cnt_bad),
        .cnt_drop  (cnt_drop)
    );

    always #4 gmii_rxc = ~gmii_rxc;

    int cyc = 0;
    always @(posedge gmii_rxc) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Output monitor: collects beats and flags bracket violations.
    int         beats, sofs, eofs, proto_viol = 0, first_valid_cyc;
    logic       last_err;
    logic [10:0] last_len;
    logic       in_frame = 1'b0;
    logic [7:0] rxq[$];

    always @(negedge gmii_rxc) begin
        if (rst) begin
            in_frame = 1'b0;
        end else if (rx_valid) begin
            if (rx_sof) begin
                if (in_frame) proto_viol++;
                in_frame = 1'b1;
                sofs++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end else if (!in_frame) begin
                proto_viol++;
            end
            beats++;
            rxq.push_back(rx_data);
            if (rx_eof) begin
                eofs++;
                last_err = rx_err;
                last_len = frame_len;
                in_frame = 1'b0;
            end
        end else if (rx_sof || rx_eof) begin
            proto_viol++;
        end
    end

    task automatic zero_mon();
        beats = 0; sofs = 0; eofs = 0; first_valid_cyc = -1;
        rxq.delete();
    endtask

    logic [7:0] frm [0:2199];
    int         frm_len;
    int         first_da_cyc;

    task automatic build_frame(input logic [47:0] da, input int len, input bit flip);
        logic [47:0] sa;
        logic [31:0] crc;
        logic        fb;
        sa = 48'h02_11_22_33_44_55;
        frm_len = len;
        for (int i = 0; i < len; i++) begin
            if (i < 6)       frm[i] = da[47-8*i -: 8];
            else if (i < 12) frm[i] = sa[47-8*(i-6) -: 8];
            else             frm[i] = 8'(i) ^ 8'h5A;
        end
        if (len >= 4) begin
            crc = 32'hFFFF_FFFF;
            for (int i = 0; i < len - 4; i++)
                for (int b = 0; b < 8; b++) begin
                    fb  = crc[0] ^ frm[i][b];
                    crc = crc >> 1;
                    if (fb) crc = crc ^ 32'hEDB8_8320;
                end
            crc = ~crc;
            for (int k = 0; k < 4; k++) frm[len-4+k] = crc[8*k +: 8];
        end
        if (flip) frm[20] = frm[20] ^ 8'h04;
    endtask

    task automatic drive(input logic en, input logic [7:0] d);
        @(posedge gmii_rxc);
        #1;
        gmii_rx_en = en;
        gmii_rxd   = d;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < frm_len; i++) begin
            drive(1'b1, frm[i]);
            if (i == 0) first_da_cyc = cyc;
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 8'h00);
    endtask

    typedef struct {
        logic [47:0] da;
        int          len;
        bit          flip;
        bit          exp_err;
        logic [10:0] exp_len;
    } vec_t;

    vec_t vecs[9];
    int   mg = 0, mb = 0, md = 0;
    int   mism;

    initial begin
        vecs[0] = '{48'h000A3501FEC0,   64, 1'b0, 1'b0, 11'd64};
        vecs[1] = '{48'h000A3501FEC0,   64, 1'b1, 1'b1, 11'd64};
        vecs[2] = '{48'hFFFFFFFFFFFF,   60, 1'b0, 1'b1, 11'd60};
        vecs[3] = '{48'hFFFFFFFFFFFF,   64, 1'b0, 1'b0, 11'd64};
        vecs[4] = '{48'h020000000001,   64, 1'b0, 1'b1, 11'd64};
        vecs[5] = '{48'h000A3501FEC0, 1518, 1'b0, 1'b0, 11'd1518};
        vecs[6] = '{48'h000A3501FEC0, 1519, 1'b0, 1'b1, 11'd1519};
        vecs[7] = '{48'h000A3501FEC0, 2100, 1'b0, 1'b1, 11'd2047};
        vecs[8] = '{48'h000A3501FEC0,    1, 1'b0, 1'b1, 11'd1};

        zero_mon();
        repeat (3) @(posedge gmii_rxc);
        @(negedge gmii_rxc);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset sof/eof/err", {rx_sof, rx_eof, rx_err}, 0);
        check("reset frame_len", frame_len, 0);
        check("reset counters", {cnt_good, cnt_bad}, 0);
        check("reset cnt_drop", cnt_drop, 0);
        @(posedge gmii_rxc); #1 rst = 1'b0;
        repeat (2) drive(1'b0, 8'h00);

        for (int v = 0; v < 9; v++) begin
            build_frame(vecs[v].da, vecs[v].len, vecs[v].flip);
            zero_mon();
            send_frame(4);
            @(negedge gmii_rxc);
            if (vecs[v].exp_err) mb++; else mg++;
            check($sformatf("vec%0d beats", v), beats, vecs[v].len);
            check($sformatf("vec%0d sof count", v), sofs, 1);
            check($sformatf("vec%0d eof count", v), eofs, 1);
            check($sformatf("vec%0d rx_err", v), last_err, vecs[v].exp_err);
            check($sformatf("vec%0d frame_len", v), last_len, vecs[v].exp_len);
            check($sformatf("vec%0d latency", v), first_valid_cyc - first_da_cyc, 2);
            mism = 0;
            for (int i = 0; i < vecs[v].len; i++)
                if (i >= rxq.size() || rxq[i] !== frm[i]) mism++;
            check($sformatf("vec%0d data mismatches", v), mism, 0);
            check($sformatf("vec%0d cnt_good", v), cnt_good, mg);
            check($sformatf("vec%0d cnt_bad", v), cnt_bad, mb);
            check($sformatf("vec%0d cnt_drop", v), cnt_drop, md);
        end

        // Bad preamble, then SFD with no data.
        zero_mon();
        drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h3C);
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);
        @(negedge gmii_rxc);
        md++;
        check("bad preamble cnt_drop", cnt_drop, md);
        drive(1'b1, 8'h55); drive(1'b1, 8'hD5);
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);
        @(negedge gmii_rxc);
        mb++;
        check("empty frame cnt_bad", cnt_bad, mb);
        check("empty frame cnt_drop", cnt_drop, md);
        // Non-preamble byte in IDLE, then rx_en drop mid-preamble.
        drive(1'b1, 8'h12); drive(1'b0, 8'h00);
        drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b0, 8'h00); drive(1'b0, 8'h00);
        @(negedge gmii_rxc);
        md += 2;
        check("idle/preamble drops", cnt_drop, md);
        check("violations emit nothing", beats + sofs + eofs, 0);
        check("violations cnt_good", cnt_good, mg);

        // Back-to-back frames with a single idle cycle.
        build_frame(48'h000A3501FEC0, 64, 1'b0);
        zero_mon();
        send_frame(1);
        send_frame(4);
        @(negedge gmii_rxc);
        mg += 2;
        check("b2b beats", beats, 128);
        check("b2b sofs", sofs, 2);
        check("b2b eofs", eofs, 2);
        check("b2b cnt_good", cnt_good, mg);
        mism = 0;
        for (int i = 0; i < 128; i++)
            if (i >= rxq.size() || rxq[i] !== frm[i % 64]) mism++;
        check("b2b data mismatches", mism, 0);

        // Reset at byte 30 while rx_en stays high.
        zero_mon();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, frm[i]);
        @(posedge gmii_rxc);
        #1;
        rst = 1'b1;
        gmii_rxd = frm[30];
        #1;
        check("midrst rx_valid", rx_valid, 0);
        check("midrst rx_data", rx_data, 0);
        check("midrst sof/eof/err", {rx_sof, rx_eof, rx_err}, 0);
        check("midrst frame_len", frame_len, 0);
        check("midrst counters", {cnt_good, cnt_bad, cnt_drop}, 0);
        @(posedge gmii_rxc);
        #1;
        rst = 1'b0;
        gmii_rxd = frm[31];
        for (int i = 32; i < 64; i++) drive(1'b1, frm[i]);
        repeat (4) drive(1'b0, 8'h00);
        @(negedge gmii_rxc);
        check("midrst no eof", eofs, 0);
        check("midrst tail ignored", {cnt_good, cnt_bad, cnt_drop}, 0);
        zero_mon();
        send_frame(4);
        @(negedge gmii_rxc);
        check("post-rst beats", beats, 64);
        check("post-rst eofs", eofs, 1);
        check("post-rst rx_err", last_err, 0);
        check("post-rst cnt_good", cnt_good, 1);
        check("post-rst cnt_bad", cnt_bad, 0);

        check("bracket violations", proto_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame_ctrl.md
Name: gmii_rx_frame_ctrl

Overview:
- Frame-level receive controller that sits directly behind the RGMII-to-GMII receive front end, in the gmii_rxc domain.
- Sequences the raw GMII byte stream: detects preamble/SFD, strips them, and delimits frames with sof/eof.
- Checks FCS, length and destination MAC, then presents a byte stream with per-frame status to the MAC/UDP layer.
- Keeps saturating good/bad/dropped frame counters for debug.

Parameters:
- LOCAL_MAC, 48'h00_0A_35_01_FE_C0, unicast address accepted by the DA filter (first transmitted byte = MSB).
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS).
- MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS).
- DA_FILTER, 1, 1 = frames whose DA is neither LOCAL_MAC nor broadcast are flagged as errors; 0 = no DA check.

Ports:
- gmii_rxc  in  1  receive clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gmii_rx_en  in  1  GMII receive data valid.
- gmii_rxd  in  8  GMII receive byte.
- rx_data  out  8  frame byte (DA through FCS; preamble/SFD removed).
- rx_valid  out  1  rx_data valid this cycle.
- rx_sof  out  1  first byte of frame (with rx_valid).
- rx_eof  out  1  last byte of frame (with rx_valid).
- rx_err  out  1  frame bad; valid only with rx_eof.
- frame_len  out  11  byte count of the frame just ended, saturating at 2047; updated with rx_eof.
- cnt_good  out  16  frames ended with rx_err=0, saturating.
- cnt_bad  out  16  frames ended with rx_err=1, plus SFD-then-empty frames, saturating.
- cnt_drop  out  16  preamble/SFD violations, saturating.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = WAIT_GAP.
  - CRC register 32'hFFFF_FFFF.
  - Hold register empty.
- FSM states:
  - WAIT_GAP: wait for gmii_rx_en=0, then go to IDLE. This prevents locking onto a frame mid-stream after reset.
  - IDLE:
    - rx_en=1 and rxd=8'h55 -> PREAMBLE, pre_cnt=1.
    - rx_en=1 with any other byte -> WAIT_GAP, cnt_drop+1.
  - PREAMBLE:
    - rxd=8'h55 -> pre_cnt+1 (3-bit, saturating at 7).
    - rxd=8'hD5 -> DATA; byte counter cleared, CRC reset to all ones.
    - Any other byte -> WAIT_GAP, cnt_drop+1.
    - rx_en falls -> IDLE, cnt_drop+1.
  - DATA:
    - Each byte with rx_en=1: CRC update, byte counter +1 (saturating at 2047), byte enters the hold stage.
    - rx_en falls -> frame end (see below), then IDLE.
- CRC: IEEE 802.3 reflected CRC-32, polynomial 0x04C11DB7, bytes processed LSB-first, init all ones. A frame passes when the register equals 32'hDEBB20E3 after the final FCS byte.
- Output pipeline:
  - Byte N is emitted on rx_data/rx_valid in the cycle after byte N+1 is sampled, or in the cycle after rx_en falls (with rx_eof=1). Input-to-output latency is therefore 2 cycles.
  - rx_sof accompanies byte 1.
  - A 1-byte frame has rx_sof=rx_eof=1 on the same beat.
  - FCS bytes are passed through.
- DA check: bytes 1..6 are compared against LOCAL_MAC and 48'hFFFF_FFFF_FFFF. A mismatch sets a sticky da_bad flag, which is used only when DA_FILTER=1. Frames shorter than 6 bytes count as da_bad.
- rx_err at eof = crc_bad OR len<MIN_LEN OR len>MAX_LEN OR (DA_FILTER AND da_bad).
- Counters:
  - cnt_good or cnt_bad increments in the same cycle as rx_eof.
  - Every counter holds at 16'hFFFF.
- Boundary cases:
  - SFD followed immediately by rx_en low: no bytes emitted, no rx_eof, cnt_bad+1, -> IDLE.
  - Minimum gap: one idle cycle between frames must suffice. The eof beat of frame k may coincide with the IDLE/first-preamble cycle of frame k+1; both are handled and no byte is lost.
  - Oversize frame: bytes continue to pass through; frame_len saturates at 2047; rx_err=1 at eof.
  - rst mid-frame: outputs cleared immediately, no eof emitted, no counter update; after release, the FSM waits in WAIT_GAP.
  - rx_valid is never asserted outside a sof..eof bracket; sof is never repeated before eof.

Test Plan:
- 7x55, D5, 64-byte frame to LOCAL_MAC with correct FCS -> 64 rx_valid beats, sof on beat 1, eof on beat 64, rx_err=0, frame_len=64, cnt_good=1, first output 2 cycles after the first DA byte.
- Same frame with one payload bit flipped -> eof with rx_err=1, cnt_bad=1, cnt_good unchanged.
- 60-byte frame with valid FCS to broadcast -> rx_err=1 (short), frame_len=60. A 64-byte broadcast frame -> rx_err=0. A 64-byte frame to 02:00:00:00:00:01 with DA_FILTER=1 -> rx_err=1.
- Preamble 55 55 3C; then 55 D5 with rx_en dropped immediately -> cnt_drop=1, cnt_bad=1, no rx_valid/sof/eof.
- Two valid 64-byte frames separated by a single rx_en=0 cycle -> two complete sof..eof brackets, 128 beats, cnt_good=2.
- rst pulsed at byte 30 of a frame while rx_en remains high -> outputs 0 and counters 0 in the same cycle. The remainder of that frame is ignored (no eof). The next frame after a gap is received normally with cnt_good=1.
